// File: rtl/ws2801_pkg.sv
// Shared types and helpers for the multi-channel WS2801 strip driver.
package ws2801_pkg;

  typedef enum logic [1:0] {LATCH, IDLE, SHIFT} state_t;

  localparam int BITS_PER_LED = 24;

  // Latch hold in clk cycles, rounded up so the strip never latches early.
  function automatic int latch_cycles(input longint freq, input longint latch_us);
    longint num;
    num = freq * latch_us + longint'(999_999);
    return int'(num / longint'(1_000_000));
  endfunction

  // (b * (br + 1)) >> 8: br=255 is identity, br=0 blanks.
  function automatic logic [7:0] scale8(input logic [7:0] b, input logic [7:0] br);
    return 8'((16'(b) * (16'(br) + 16'd1)) >> 8);
  endfunction

endpackage

// File: rtl/ws2801_strip_driver_if.sv
// Frame-source side of the strip driver: frame, brightness and start/ready handshake.
interface ws2801_strip_driver_if import ws2801_pkg::*; #(
  parameter int CHANNELS = 2,
  parameter int LEDS     = 50
);
  logic [CHANNELS*LEDS*BITS_PER_LED-1:0] led_rgb;
  logic [7:0]                            brightness;
  logic                                  start;
  logic                                  ready;
  logic                                  frame_done;

  modport master (output led_rgb, brightness, start, input  ready, frame_done);
  modport slave  (input  led_rgb, brightness, start, output ready, frame_done);
endinterface

// File: rtl/ws2801_bit_clk.sv
// Serial bit-clock divider: registered sclk level plus strobes marking the
// cycle at whose end sclk rises or falls. Held cleared while en is low.
module ws2801_bit_clk #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic fall,
  output logic rise
);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;

  logic [DW-1:0] cnt, cnt_nxt;

  assign cnt_nxt = (cnt == DW'(CLK_DIV-1)) ? '0 : cnt + 1'b1;
  assign fall    = en && (cnt == DW'(CLK_DIV-1));
  assign rise    = en && (cnt == DW'(HALF-1));

  // sclk tracks (cnt >= HALF) one register stage ahead, so it is never gated.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      sclk <= (cnt_nxt >= DW'(HALF));
    end
  end
endmodule

// File: rtl/ws2801_strip_driver.sv
// Multi-channel WS2801 driver: captures a frame on start, shifts every strip
// MSB first on one shared sclk with per-byte brightness scaling, then latches.
module ws2801_strip_driver import ws2801_pkg::*; #(
  parameter int CHANNELS = 2,
  parameter int LEDS     = 50,
  parameter int FREQ     = 12_500_000,
  parameter int CLK_DIV  = 4,
  parameter int LATCH_US = 500
) (
  input  logic                clk,
  input  logic                rst,
  ws2801_strip_driver_if.slave bus,
  output logic                sclk,
  output logic [CHANNELS-1:0] sdo
);
  localparam int NBITS        = LEDS * BITS_PER_LED;
  localparam int LATCH_CYCLES = latch_cycles(longint'(FREQ), longint'(LATCH_US));
  localparam int BW           = $clog2(NBITS);
  localparam int LW           = $clog2(LATCH_CYCLES + 1);

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt;
  logic [LW-1:0] latch_cnt;
  logic [7:0]    bright_q;
  logic          from_shift, last_armed, frame_done_q;
  logic          bit_fall, bit_rise, accept, byte_end, last_bit;

  assign accept         = (state_q == IDLE) && bus.start;
  assign last_bit       = (bit_cnt == BW'(NBITS-1));
  assign byte_end       = bit_fall && (bit_cnt[2:0] == 3'b111) && !last_armed;
  assign bus.ready      = (state_q == IDLE);
  assign bus.frame_done = frame_done_q;

  ws2801_bit_clk #(.CLK_DIV(CLK_DIV)) u_bit_clk (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q == SHIFT),
    .sclk (sclk),
    .fall (bit_fall),
    .rise (bit_rise)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      LATCH:   if (latch_cnt == LW'(LATCH_CYCLES-1)) state_d = IDLE;
      IDLE:    if (bus.start)                        state_d = SHIFT;
      SHIFT:   if (bit_fall && last_armed)           state_d = LATCH;
      default:                                       state_d = LATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LATCH;
      latch_cnt    <= '0;
      bit_cnt      <= '0;
      from_shift   <= 1'b0;
      last_armed   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= (state_q == LATCH) && (state_d == IDLE) && from_shift;
      latch_cnt    <= (state_q == LATCH && state_d == LATCH) ? latch_cnt + 1'b1 : '0;
      if (state_q != SHIFT || state_d != SHIFT) bit_cnt <= '0;
      else if (bit_fall)                        bit_cnt <= bit_cnt + 1'b1;
      // Armed at the last bit's rising edge; its falling edge ends the frame.
      if (state_d != SHIFT)            last_armed <= 1'b0;
      else if (bit_rise && last_bit)   last_armed <= 1'b1;
      if (state_q == SHIFT && state_d == LATCH) from_shift <= 1'b1;
      else if (state_d == IDLE)                 from_shift <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) bright_q <= bus.brightness;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [NBITS-1:0] frame_q;
    logic [7:0]       sreg, src, scaled;

    // Byte 0 is scaled straight from the inputs at accept; later bytes come
    // from the captured frame, which slides left one byte per byte sent.
    assign src    = accept ? bus.led_rgb[c*NBITS + NBITS-1 -: 8] : frame_q[NBITS-9 -: 8];
    assign scaled = scale8(src, accept ? bus.brightness : bright_q);
    assign sdo[c] = sreg[7];

    always_ff @(posedge clk) begin
      if (accept)        frame_q <= bus.led_rgb[c*NBITS +: NBITS];
      else if (byte_end) frame_q <= frame_q << 8;
    end

    always_ff @(posedge clk) begin
      if (rst)                    sreg <= '0;
      else if (accept)            sreg <= scaled;
      else if (state_q != SHIFT)  sreg <= '0;
      else if (bit_fall) begin
        if (last_armed)           sreg <= '0;
        else if (byte_end)        sreg <= scaled;
        else                      sreg <= sreg << 1;
      end
    end
  end
endmodule

// File: tb/tb_ws2801_strip_driver.sv
// Directed bench: reset/latch timing, bit order, scaling, capture isolation,
// mid-frame reset, and sclk/sdo timing at two other divider settings.
module tb_ws2801_strip_driver;
  localparam int LA  = 25;   // ceil(12.5 MHz * 2 us)
  localparam int LBC = 13;   // ceil(12.5 MHz * 1 us)

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  ws2801_strip_driver_if #(.CHANNELS(2), .LEDS(1)) if_a ();
  ws2801_strip_driver_if #(.CHANNELS(1), .LEDS(1)) if_b ();
  ws2801_strip_driver_if #(.CHANNELS(1), .LEDS(1)) if_c ();

  logic       sclk_a, sclk_b, sclk_c;
  logic [1:0] sdo_a;
  logic [0:0] sdo_b, sdo_c;

  ws2801_strip_driver #(.CHANNELS(2), .LEDS(1), .FREQ(12_500_000), .CLK_DIV(4), .LATCH_US(2))
    dut_a (.clk(clk), .rst(rst), .bus(if_a), .sclk(sclk_a), .sdo(sdo_a));
  ws2801_strip_driver #(.CHANNELS(1), .LEDS(1), .FREQ(12_500_000), .CLK_DIV(2), .LATCH_US(1))
    dut_b (.clk(clk), .rst(rst), .bus(if_b), .sclk(sclk_b), .sdo(sdo_b));
  ws2801_strip_driver #(.CHANNELS(1), .LEDS(1), .FREQ(12_500_000), .CLK_DIV(6), .LATCH_US(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c), .sclk(sclk_c), .sdo(sdo_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready_a(output int n, output int nfd, output int noise);
    n = 0; nfd = 0; noise = 0;
    while (!if_a.ready && n < 1000) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (if_a.frame_done) nfd++;
      if (sclk_a || sdo_a != 2'b00) noise++;
    end
  endtask

  task automatic frame_a(input logic [47:0] led, input logic [7:0] br, input bit poke,
                         output logic [23:0] r0, output logic [23:0] r1,
                         output int lat, output int nrise, output int nfd, output logic fd_last);
    logic ps;
    @(negedge clk);
    if_a.led_rgb = led; if_a.brightness = br; if_a.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if_a.start = 1'b0;
    if (poke) begin if_a.led_rgb = {2{24'h555555}}; if_a.brightness = 8'd0; end
    r0 = '0; r1 = '0; lat = 1; nrise = 0; nfd = 0; ps = sclk_a;
    while (!if_a.ready && lat < 2000) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if_a.start = poke && (lat == 40);
      if (!ps && sclk_a) begin
        r0 = {r0[22:0], sdo_a[0]};
        r1 = {r1[22:0], sdo_a[1]};
        nrise++;
      end
      ps = sclk_a;
      if (if_a.frame_done) nfd++;
    end
    fd_last = if_a.frame_done;
    if_a.start = 1'b0;
  endtask

  task automatic run_a(input string tag, input logic [47:0] led, input logic [7:0] br,
                       input bit poke, input logic [23:0] e0, input logic [23:0] e1);
    logic [23:0] r0, r1;
    int lat, nrise, nfd;
    logic fdl;
    frame_a(led, br, poke, r0, r1, lat, nrise, nfd, fdl);
    check({tag, "_ch0"},     r0,    e0);
    check({tag, "_ch1"},     r1,    e1);
    check({tag, "_latency"}, lat,   1 + 24*4 + LA);
    check({tag, "_rises"},   nrise, 24);
    check({tag, "_fd_cnt"},  nfd,   1);
    check({tag, "_fd_rdy"},  fdl,   1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nfd, noise, k, cyc, bad;
    logic [23:0] rx [2];
    int hi [2], rise [2], viol [2], lat [2];
    logic ps [2], pd [2], pr [2];
    bit done [2];
    logic [1:0] s, d, r;

    if_a.start = 1'b0; if_a.led_rgb = '0; if_a.brightness = '0;
    if_b.start = 1'b0; if_b.led_rgb = '0; if_b.brightness = '0;
    if_c.start = 1'b0; if_c.led_rgb = '0; if_c.brightness = '0;

    // Reset and first latch period
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", if_a.ready,      1'b0);
    check("rst_fd",    if_a.frame_done, 1'b0);
    check("rst_sclk",  sclk_a,          1'b0);
    check("rst_sdo",   sdo_a,           2'b00);
    rst = 1'b0;
    wait_ready_a(n, nfd, noise);
    check("rst_to_ready", n,     LA);
    check("rst_no_fd",    nfd,   0);
    check("rst_quiet",    noise, 0);

    // Bit order, scaling, capture isolation
    run_a("order",  {24'h000001, 24'h800000}, 8'd255, 1'b0, 24'h800000, 24'h000001);
    run_a("br127",  {24'hFFFFFF, 24'hFFFFFF}, 8'd127, 1'b0, 24'h7F7F7F, 24'h7F7F7F);
    run_a("br0",    {24'hFFFFFF, 24'hFFFFFF}, 8'd0,   1'b0, 24'h000000, 24'h000000);
    run_a("half",   {24'h102040, 24'h80FF01}, 8'd127, 1'b0, 24'h407F00, 24'h081020);
    run_a("poke",   {24'h123456, 24'hA5C30F}, 8'd255, 1'b1, 24'hA5C30F, 24'h123456);

    bad = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (!if_a.ready || sclk_a || if_a.frame_done) bad++;
    end
    check("no_second_frame", bad, 0);

    // Reset in the middle of a frame, during an sclk high phase
    @(negedge clk);
    if_a.led_rgb = {2{24'hFFFFFF}}; if_a.brightness = 8'd255; if_a.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if_a.start = 1'b0;
    k = 1;
    while (k < 48) begin @(posedge clk); @(negedge clk); k++; end
    check("pre_rst_sclk", sclk_a, 1'b1);
    check("pre_rst_sdo",  sdo_a,  2'b11);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("midrst_sclk",  sclk_a,     1'b0);
    check("midrst_sdo",   sdo_a,      2'b00);
    check("midrst_ready", if_a.ready, 1'b0);
    rst = 1'b0;
    wait_ready_a(n, nfd, noise);
    check("midrst_to_ready", n,     LA);
    check("midrst_no_fd",    nfd,   0);
    check("midrst_quiet",    noise, 0);

    // CLK_DIV=2 (b) and CLK_DIV=6 (c) run side by side
    @(negedge clk);
    check("bc_ready", {if_c.ready, if_b.ready}, 2'b11);
    for (int g = 0; g < 2; g++) begin
      rx[g] = '0; hi[g] = 0; rise[g] = 0; viol[g] = 0; lat[g] = 0; done[g] = 1'b0;
      ps[g] = 1'b0; pd[g] = 1'b0; pr[g] = 1'b1;
    end
    if_b.led_rgb = 24'hC3A501; if_b.brightness = 8'd255; if_b.start = 1'b1;
    if_c.led_rgb = 24'h5A0FF0; if_c.brightness = 8'd255; if_c.start = 1'b1;
    @(posedge clk); @(negedge clk);
    if_b.start = 1'b0; if_c.start = 1'b0;
    cyc = 1;
    while (!(done[0] && done[1]) && cyc < 400) begin
      s = {sclk_c, sclk_b}; d = {sdo_c[0], sdo_b[0]}; r = {if_c.ready, if_b.ready};
      for (int g = 0; g < 2; g++) begin
        if (!done[g]) begin
          if (r[g]) begin
            done[g] = 1'b1; lat[g] = cyc;
          end else begin
            if (s[g]) hi[g]++;
            if (!ps[g] && s[g]) begin rx[g] = {rx[g][22:0], d[g]}; rise[g]++; end
            if (d[g] != pd[g] && !(ps[g] && !s[g]) && !pr[g]) viol[g]++;
          end
          ps[g] = s[g]; pd[g] = d[g]; pr[g] = r[g];
        end
      end
      if (!(done[0] && done[1])) begin @(posedge clk); @(negedge clk); cyc++; end
    end
    check("div2_data",    rx[0],   24'hC3A501);
    check("div2_latency", lat[0],  1 + 24*2 + LBC);
    check("div2_high",    hi[0],   24);
    check("div2_rises",   rise[0], 24);
    check("div2_stable",  viol[0], 0);
    check("div6_data",    rx[1],   24'h5A0FF0);
    check("div6_latency", lat[1],  1 + 24*6 + LBC);
    check("div6_high",    hi[1],   72);
    check("div6_rises",   rise[1], 24);
    check("div6_stable",  viol[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
